// File: rtl/sram_elem_rmw.sv
// Element-granular read-modify-write front end for one port of a dual-port SRAM.
// Sequences each request through a read cycle and, for writes, a merged write-back.
module sram_elem_rmw #(
    parameter int WIDTH      = 32,
    parameter int ELEM_WIDTH = 8,
    parameter int LG_ELEMS   = 2,
    parameter int LG_DEPTH   = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic                  req_acc,
    input  logic [LG_DEPTH-1:0]   req_addr,
    input  logic [LG_ELEMS-1:0]   req_elem,
    input  logic [ELEM_WIDTH-1:0] req_data,
    output logic                  resp_valid,
    output logic [WIDTH-1:0]      resp_data,
    output logic [LG_DEPTH-1:0]   sram_addr,
    output logic [WIDTH-1:0]      sram_din,
    output logic                  sram_we,
    input  logic [WIDTH-1:0]      sram_dout
);

    localparam int ELEMS = WIDTH / ELEM_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        MOD  = 2'd2
    } state_t;

    state_t                state, next_state;
    logic                  write_q;
    logic                  acc_q;
    logic [LG_DEPTH-1:0]   addr_q;
    logic [LG_ELEMS-1:0]   elem_q;
    logic [ELEM_WIDTH-1:0] data_q;
    logic [WIDTH-1:0]      merged;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            write_q <= 1'b0;
            acc_q   <= 1'b0;
            addr_q  <= '0;
            elem_q  <= '0;
            data_q  <= '0;
        end else begin
            state <= next_state;
            if (req_valid && req_ready) begin
                write_q <= req_write;
                acc_q   <= req_acc;
                addr_q  <= req_addr;
                elem_q  <= req_elem;
                data_q  <= req_data;
            end
        end
    end

    // Replace only the selected element; accumulate wraps modulo 2^ELEM_WIDTH.
    always_comb begin
        merged = sram_dout;
        for (int i = 0; i < ELEMS; i++) begin
            if (elem_q == LG_ELEMS'(i)) begin
                if (acc_q)
                    merged[i*ELEM_WIDTH +: ELEM_WIDTH] =
                        sram_dout[i*ELEM_WIDTH +: ELEM_WIDTH] + data_q;
                else
                    merged[i*ELEM_WIDTH +: ELEM_WIDTH] = data_q;
            end
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state;
        req_ready  = 1'b0;
        sram_we    = 1'b0;
        resp_valid = 1'b0;
        sram_din   = '0;
        resp_data  = '0;
        sram_addr  = addr_q;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid)
                    next_state = RD;
            end
            RD: begin
                next_state = MOD;
            end
            MOD: begin
                next_state = IDLE;
                if (write_q) begin
                    sram_we  = 1'b1;
                    sram_din = merged;
                end else begin
                    resp_valid = 1'b1;
                    resp_data  = sram_dout;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_elem_rmw.sv
// Directed self-checking bench for sram_elem_rmw with a one-cycle-latency SRAM model.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sram_elem_rmw;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_acc;
    logic [5:0]  req_addr;
    logic [1:0]  req_elem;
    logic [7:0]  req_data;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [5:0]  sram_addr;
    logic [31:0] sram_din;
    logic        sram_we;
    logic [31:0] sram_dout;

    logic [31:0] mem [64];

    int n_assert = 0;
    int n_fail   = 0;
    int we_count;
    int resp_count;

    always #5 clk = ~clk;

    sram_elem_rmw dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_acc    (req_acc),
        .req_addr   (req_addr),
        .req_elem   (req_elem),
        .req_data   (req_data),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .sram_addr  (sram_addr),
        .sram_din   (sram_din),
        .sram_we    (sram_we),
        .sram_dout  (sram_dout)
    );

    // Read-first SRAM port: data for the address presented in one cycle appears the next.
    always @(posedge clk) begin
        if (sram_we)
            mem[sram_addr] <= sram_din;
        sram_dout <= mem[sram_addr];
    end

    always @(posedge clk) begin
        if (sram_we)
            we_count++;
        if (resp_valid)
            resp_count++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request at a falling edge and walks it through RD, MOD and back to IDLE.
    task automatic run_req(input string tag, input logic w, input logic acc,
                           input logic [5:0] addr, input logic [1:0] elem,
                           input logic [7:0] data, input logic [31:0] exp_word);
        check({tag, " ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_acc   = acc;
        req_addr  = addr;
        req_elem  = elem;
        req_data  = data;
        we_count  = 0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        req_write = ~w;
        req_addr  = ~addr;
        req_elem  = ~elem;
        req_data  = ~data;
        check({tag, " rd_ready"}, 32'(req_ready), 32'd0);
        check({tag, " rd_addr"}, 32'(sram_addr), 32'(addr));
        check({tag, " rd_we"}, 32'(sram_we), 32'd0);
        @(negedge clk);
        check({tag, " mod_we"}, 32'(sram_we), 32'(w));
        check({tag, " mod_resp_valid"}, 32'(resp_valid), 32'(!w));
        check({tag, " mod_addr"}, 32'(sram_addr), 32'(addr));
        if (w) begin
            check({tag, " mod_din"}, sram_din, exp_word);
            check({tag, " mod_resp_data"}, resp_data, 32'd0);
        end else begin
            check({tag, " mod_resp_data"}, resp_data, exp_word);
            check({tag, " mod_din"}, sram_din, 32'd0);
        end
        @(negedge clk);
        check({tag, " post_ready"}, 32'(req_ready), 32'd1);
        check({tag, " post_we"}, 32'(sram_we), 32'd0);
        check({tag, " post_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, " we_cycles"}, 32'(we_count), 32'(w));
        check({tag, " mem_word"}, mem[addr], exp_word);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++)
            mem[i] = 32'd0;
        mem[5]  = 32'h11223344;
        mem[3]  = 32'h000000F0;
        mem[63] = 32'hDEADBEEF;
        mem[7]  = 32'h55667788;

        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_acc   = 1'b0;
        req_addr  = '0;
        req_elem  = '0;
        req_data  = '0;
        #1;
        check("reset ready", 32'(req_ready), 32'd1);
        check("reset we", 32'(sram_we), 32'd0);
        check("reset resp_valid", 32'(resp_valid), 32'd0);
        check("reset addr", 32'(sram_addr), 32'd0);
        check("reset din", sram_din, 32'd0);
        check("reset resp_data", resp_data, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_req("overwrite", 1'b1, 1'b0, 6'd5, 2'd1, 8'hAA, 32'h1122AA44);
        run_req("acc_wrap", 1'b1, 1'b1, 6'd3, 2'd0, 8'h20, 32'h00000010);
        resp_count = 0;
        run_req("read63", 1'b0, 1'b0, 6'd63, 2'd2, 8'h00, 32'hDEADBEEF);
        check("read63 resp_pulses", 32'(resp_count), 32'd1);

        // Four accumulates held valid: handshakes every third cycle.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_acc   = 1'b1;
        req_addr  = 6'd0;
        req_elem  = 2'd3;
        req_data  = 8'h01;
        for (int i = 0; i < 12; i++) begin
            if (i == 10)
                req_valid = 1'b0;
            check($sformatf("b2b ready cyc%0d", i), 32'(req_ready), 32'((i % 3) == 0));
            @(posedge clk);
            @(negedge clk);
        end
        check("b2b ready_end", 32'(req_ready), 32'd1);
        check("b2b word0", mem[0], 32'h04000000);

        // Reset during RD of an overwrite aborts it.
        resp_count = 0;
        we_count   = 0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_acc   = 1'b0;
        req_addr  = 6'd7;
        req_elem  = 2'd2;
        req_data  = 8'hCC;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort in_rd", 32'(req_ready), 32'd0);
        reset_n = 1'b0;
        #1;
        check("abort ready", 32'(req_ready), 32'd1);
        check("abort we", 32'(sram_we), 32'd0);
        check("abort resp_valid", 32'(resp_valid), 32'd0);
        check("abort addr", 32'(sram_addr), 32'd0);
        check("abort din", sram_din, 32'd0);
        check("abort resp_data", resp_data, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort word7", mem[7], 32'h55667788);
        check("abort no_we", 32'(we_count), 32'd0);
        check("abort no_resp", 32'(resp_count), 32'd0);
        check("abort ready_after", 32'(req_ready), 32'd1);
        run_req("fresh", 1'b1, 1'b0, 6'd7, 2'd2, 8'hCC, 32'h55CC7788);

        run_req("bound e0a0", 1'b1, 1'b0, 6'd0, 2'd0, 8'h5A, 32'h0400005A);
        run_req("bound e3a63", 1'b1, 1'b0, 6'd63, 2'd3, 8'h12, 32'h12ADBEEF);
        run_req("bound rd0", 1'b0, 1'b0, 6'd0, 2'd0, 8'h00, 32'h0400005A);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
